// File: rtl/seven_seg_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_digit_scanner
// Description : Time-multiplexes an N-digit hex value onto a shared 4-bit
//               nibble bus with one-hot digit enables. A guard gap before
//               each digit hides the downstream encoder latency. New values
//               are double-buffered and take effect only at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_digit_scanner #(
  parameter int NUM_DIGITS   = 2,
  parameter int DIGIT_CYCLES = 25000,
  parameter int GUARD_CYCLES = 250
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic                    i_Load,
  input  logic                    i_Blank_Lz,
  output logic [3:0]              o_Binary_Num,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Frame_Done
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int IW         = $clog2(NUM_DIGITS);
  localparam int VW         = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] C_GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] C_DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0] C_LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [VW-1:0]           active_q, active_d;
  logic [VW-1:0]           pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [3:0]              nib_q, nib_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0]   blank;
  logic                    hi_zero;
  logic [3:0]              nib_sel;

  // Leading-zero mask: a digit is blanked when it and every digit above it are zero.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      hi_zero  = hi_zero && (active_q[4*k +: 4] == 4'd0);
      blank[k] = i_Blank_Lz && hi_zero;
    end
  end

  // Sequencer next state, double-buffer transfer and registered output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    nib_d        = nib_q;
    frame_done_d = 1'b0;
    en_d         = '0;
    nib_sel      = 4'd0;

    case (state_q)
      ST_GUARD: begin
        if (cnt_q == C_GUARD_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == C_DIGIT_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          if (idx_q == C_LAST_IDX) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            if (pend_valid_q) begin
              active_d = pend_q;
            end
            pend_valid_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_GUARD;
        cnt_d   = '0;
      end
    endcase

    // A load on the boundary edge lands after the transfer, so set beats clear.
    if (i_Load) begin
      pend_d       = i_Value;
      pend_valid_d = 1'b1;
    end

    // The nibble only moves on the SHOW->GUARD edge, giving the encoder a full guard gap.
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nib_sel = active_d[4*k +: 4];
      end
    end
    if ((state_q == ST_SHOW) && (state_d == ST_GUARD)) begin
      nib_d = nib_sel;
    end

    if ((state_d == ST_SHOW) && !blank[idx_d]) begin
      en_d[idx_d] = 1'b1;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      nib_q        <= 4'd0;
      en_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      nib_q        <= nib_d;
      en_q         <= en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_Binary_Num = nib_q;
  assign o_Digit_En   = en_q;
  assign o_Frame_Done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_digit_scanner
// Description : Self-checking bench for seven_seg_digit_scanner. A timeline
//               model derives the expected outputs from the cycle position
//               within the frame; directed tests pin it with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_digit_scanner;

  localparam int NUM   = 2;
  localparam int DC    = 4;
  localparam int GC    = 2;
  localparam int SLOT  = GC + DC;
  localparam int FRAME = NUM * SLOT;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     val = 8'h00;
  logic           load = 1'b0;
  logic           blz = 1'b0;
  logic [3:0]     nib;
  logic [NUM-1:0] en;
  logic           fd;

  seven_seg_digit_scanner #(
    .NUM_DIGITS  (NUM),
    .DIGIT_CYCLES(DC),
    .GUARD_CYCLES(GC)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Value     (val),
    .i_Load      (load),
    .i_Blank_Lz  (blz),
    .o_Binary_Num(nib),
    .o_Digit_En  (en),
    .o_Frame_Done(fd)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: m_t is the index of the current cycle since reset release.
  int         m_t;
  logic [7:0] m_act, m_pend;
  bit         m_pv, m_blz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_act = 8'h00; m_pend = 8'h00; m_pv = 0; m_blz = 0;
    end else begin
      if ((m_t % FRAME) == FRAME - 1) begin
        if (m_pv) m_act = m_pend;
        m_pv = 0;
      end
      if (load) begin
        m_pend = val;
        m_pv   = 1;
      end
      m_blz = blz;
      m_t++;
    end
  end

  function automatic void model_out(output logic [3:0] e_nib, output logic [NUM-1:0] e_en,
                                    output logic e_fd);
    int  p, d;
    bit  show, blanked;
    p       = m_t % FRAME;
    d       = p / SLOT;
    show    = (p % SLOT) >= GC;
    e_nib   = 4'(m_act >> (4 * d));
    blanked = m_blz && (d > 0) && ((m_act >> (4 * d)) == 8'h00);
    e_en    = (show && !blanked) ? NUM'(1 << d) : '0;
    e_fd    = (p == 0) && (m_t > 0);
  endfunction

  // Per-cycle comparison against the model plus structural invariants.
  logic [3:0]     prev_nib = 4'd0;
  logic [NUM-1:0] prev_en = '0;
  logic           prev_rst = 1'b0;
  always @(negedge clk) begin
    logic [3:0]     e_nib;
    logic [NUM-1:0] e_en;
    logic           e_fd;
    if (!rst_n) begin
      check("rst_outputs", 32'({nib, en, fd}), 32'd0);
    end else begin
      model_out(e_nib, e_en, e_fd);
      check("nib", 32'(nib), 32'(e_nib));
      check("en", 32'(en), 32'(e_en));
      check("frame_done", 32'(fd), 32'(e_fd));
      check("en_onehot0", 32'($onehot0(en)), 32'd1);
      if (prev_rst && (prev_en == '0) && (en != '0))
        check("nib_stable_before_en", 32'(nib), 32'(prev_nib));
    end
    prev_nib = nib;
    prev_en  = en;
    prev_rst = rst_n;
  end

  // Advance to the cycle whose frame position is p (sampled 1 ns after the edge).
  task automatic goto(input int p);
    int guard_cnt;
    guard_cnt = 0;
    while ((m_t % FRAME) != p) begin
      @(posedge clk); #1;
      guard_cnt++;
      if (guard_cnt > 2 * FRAME) begin
        check("goto_timeout", 32'(guard_cnt), 32'(p));
        return;
      end
    end
  endtask

  task automatic pulse_load(input logic [7:0] v);
    val  = v;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_nib", 32'(nib), 32'd0);
    check("reset_en", 32'(en), 32'd0);
    rst_n = 1'b1;

    // 1: idle scan pattern and frame pulse
    goto(2);  check("t1_en_d0", 32'(en), 32'h1);
    goto(6);  check("t1_en_guard", 32'(en), 32'h0);
    goto(8);  check("t1_en_d1", 32'(en), 32'h2);
    goto(0);  check("t1_frame_done", 32'(fd), 32'h1);

    // 2: mid-frame load applies at the next boundary
    goto(3);  pulse_load(8'hA5);
    goto(8);  check("t2_nib_unchanged", 32'(nib), 32'h0);
    goto(0);  check("t2_nib_guard0", 32'(nib), 32'h5);
    goto(2);  check("t2_nib_d0", 32'(nib), 32'h5);
    goto(8);  check("t2_nib_d1", 32'(nib), 32'hA);

    // 3: last load wins; load on the boundary edge waits one frame
    goto(1);  pulse_load(8'h12);
    goto(4);  pulse_load(8'h34);
    goto(11); pulse_load(8'h56);
    goto(2);  check("t3_nib_d0", 32'(nib), 32'h4);
    goto(8);  check("t3_nib_d1", 32'(nib), 32'h3);
    goto(2);  check("t3_next_d0", 32'(nib), 32'h6);
    goto(8);  check("t3_next_d1", 32'(nib), 32'h5);

    // 4: leading-zero blanking
    blz = 1'b1;
    goto(3);  pulse_load(8'h07);
    goto(2);  check("t4_nib7", 32'(nib), 32'h7);
              check("t4_en_d0", 32'(en), 32'h1);
    goto(8);  check("t4_blank_d1", 32'(en), 32'h0);
    goto(11); check("t4_blank_d1_end", 32'(en), 32'h0);
    goto(0);  check("t4_period", 32'(fd), 32'h1);
    goto(3);  pulse_load(8'h00);
    goto(2);  check("t4_zero_d0_en", 32'(en), 32'h1);
              check("t4_zero_d0_nib", 32'(nib), 32'h0);
    blz = 1'b0;
    goto(8);  check("t4_noblank_en", 32'(en), 32'h2);
              check("t4_noblank_nib", 32'(nib), 32'h0);

    // 5: random-load soak with occasional blanking changes
    repeat (1000 * FRAME) begin
      load = (($urandom % 8) == 0);
      val  = 8'($urandom);
      if (($urandom % 50) == 0) blz = ~blz;
      @(posedge clk); #1;
    end
    load = 1'b0;
    blz  = 1'b0;

    // 6: asynchronous reset during digit-1 SHOW discards the pending load
    goto(3);  pulse_load(8'hCC);
    goto(9);  check("t6_pre_en", 32'(en), 32'h2);
    rst_n = 1'b0;
    #1;
    check("t6_async_nib", 32'(nib), 32'h0);
    check("t6_async_en", 32'(en), 32'h0);
    check("t6_async_fd", 32'(fd), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    goto(2);  check("t6_restart_en", 32'(en), 32'h1);
              check("t6_restart_nib", 32'(nib), 32'h0);
    goto(8);  check("t6_d1_nib", 32'(nib), 32'h0);
    goto(2);  check("t6_discard_d0", 32'(nib), 32'h0);
    goto(8);  check("t6_discard_d1", 32'(nib), 32'h0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
